// File: rtl/attractor_classifier.sv
// attractor_classifier
// --------------------
// Watches the state sequence of a gene network and finds its attractor.
// Each accepted sample is compared against every state seen so far in the
// run. The first repeat ends the run. If the history fills up without a
// repeat, the run ends as an overflow.
//
// Parameters
//   DEPTH       history depth in states (2..16)
//
// Ports
//   clk         clock, rising edge active
//   rst         asynchronous active-high reset
//   start       begin a new classification run (accepted only when idle)
//   x           current network state
//   x_valid     x carries a new state this cycle
//   busy        a run is in progress (TRACK or REPORT)
//   done        one-cycle pulse, results valid
//   attr_type   00 none, 01 fixed point, 10 cycle, 11 overflow
//   period      attractor length in states
//   transient   states seen before entering the attractor
//   attr_state  first repeated state (last state on overflow)
//   n_samples   samples accepted in the run
module attractor_classifier #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x,
  input  logic       x_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] attr_type,
  output logic [4:0] period,
  output logic [4:0] transient,
  output logic [7:0] attr_state,
  output logic [4:0] n_samples
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    REPORT
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [7:0]       hist [DEPTH];
  logic [DEPTH-1:0] hist_valid;
  logic [4:0]       n;

  logic             start_ok;
  logic             accept;
  logic             last_slot;
  logic             match_found;
  logic [4:0]       match_idx;
  logic [4:0]       match_period;

  assign start_ok     = (state == IDLE) && start;
  assign accept       = (state == TRACK) && x_valid;
  assign last_slot    = (n == 5'(DEPTH - 1));
  assign match_period = n - match_idx;

  assign busy = (state != IDLE);
  assign done = (state == REPORT);

  // Compare the incoming sample against every valid history entry at once.
  // The loop walks from the top index down so that, should several entries
  // ever match, the lowest index is the one left in match_idx.
  always_comb begin
    match_found = 1'b0;
    match_idx   = 5'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hist_valid[i] && (hist[i] == x)) begin
        match_found = 1'b1;
        match_idx   = 5'(i);
      end
    end
  end

  // Run sequencing: a start in IDLE opens a run, a matching sample or a
  // sample landing in the last history slot closes it, and REPORT always
  // lasts exactly one cycle before dropping back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (x_valid && (match_found || last_slot)) begin
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register. Reset lands in IDLE, which also forces busy and done low
  // because both are decoded straight from the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run bookkeeping and result registers. Accepting start wipes the history
  // valid bits, the sample index and the previous results. A non-matching
  // sample claims slot n; the slot n = DEPTH-1 case also publishes an
  // overflow result, leaving n at DEPTH so it never runs past the history.
  // Results are held untouched from REPORT until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_valid <= '0;
      n          <= 5'd0;
      attr_type  <= 2'b00;
      period     <= 5'd0;
      transient  <= 5'd0;
      attr_state <= 8'h00;
      n_samples  <= 5'd0;
    end else if (start_ok) begin
      hist_valid <= '0;
      n          <= 5'd0;
      attr_type  <= 2'b00;
      period     <= 5'd0;
      transient  <= 5'd0;
      attr_state <= 8'h00;
      n_samples  <= 5'd0;
    end else if (accept) begin
      if (match_found) begin
        attr_type  <= (match_period == 5'd1) ? 2'b01 : 2'b10;
        period     <= match_period;
        transient  <= match_idx;
        attr_state <= x;
        n_samples  <= n + 5'd1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (5'(i) == n) begin
            hist_valid[i] <= 1'b1;
          end
        end
        n <= n + 5'd1;
        if (last_slot) begin
          attr_type  <= 2'b11;
          period     <= 5'd0;
          transient  <= 5'd0;
          attr_state <= x;
          n_samples  <= 5'(DEPTH);
        end
      end
    end
  end

  // History storage. The data itself needs no reset because an entry is
  // only ever looked at once its valid bit has been set.
  always_ff @(posedge clk) begin
    if (accept && !match_found) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (5'(i) == n) begin
          hist[i] <= x;
        end
      end
    end
  end

endmodule

// File: tb/tb_attractor_classifier.sv
// tb_attractor_classifier
// -----------------------
// Self-checking bench for attractor_classifier. Each run pushes its
// expected result, worked out by a small reference model of the sequence,
// onto a scoreboard queue. A monitor pops and compares whenever done pulses.
module tb_attractor_classifier;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic       x_valid;
  logic       busy;
  logic       done;
  logic [1:0] attr_type;
  logic [4:0] period;
  logic [4:0] transient;
  logic [7:0] attr_state;
  logic [4:0] n_samples;

  typedef struct {
    int t;
    int p;
    int tr;
    int s;
    int n;
    int decide;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] stim  [$];
  int         total;
  int         bad;
  int         done_count;
  int         runs;

  attractor_classifier #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done),
    .attr_type  (attr_type),
    .period     (period),
    .transient  (transient),
    .attr_state (attr_state),
    .n_samples  (n_samples)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything in the stimulus stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check funnels through here.
  task automatic checkOutput(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Reference model: scan the sample list for the first state that repeats
  // an earlier one, or for the sample that fills the last history slot.
  function automatic exp_t model();
    exp_t e;
    e = '{0, 0, 0, 0, 0, -1};
    for (int j = 0; j < stim.size(); j++) begin
      for (int k = 0; k < j; k++) begin
        if (stim[k] == stim[j]) begin
          e.p      = j - k;
          e.tr     = k;
          e.s      = int'(stim[j]);
          e.n      = j + 1;
          e.t      = (e.p == 1) ? 1 : 2;
          e.decide = j;
          return e;
        end
      end
      if (j == DEPTH - 1) begin
        e.t      = 3;
        e.s      = int'(stim[j]);
        e.n      = DEPTH;
        e.decide = j;
        return e;
      end
    end
    return e;
  endfunction

  // Scoreboard side: every done pulse must have an expected result waiting.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_count++;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("attr_type", int'(attr_type), e.t);
        checkOutput("period", int'(period), e.p);
        checkOutput("transient", int'(transient), e.tr);
        checkOutput("attr_state", int'(attr_state), e.s);
        checkOutput("n_samples", int'(n_samples), e.n);
      end
    end
  end

  // Opens a run. The start cycle also carries a valid copy of the first
  // sample, which must not be recorded. Optionally releases reset on the
  // same edge so start lands on the first rising edge after reset.
  task automatic startRun(input bit release_rst);
    @(negedge clk);
    if (release_rst) rst = 1'b0;
    start   = 1'b1;
    x_valid = 1'b1;
    x       = (stim.size() > 0) ? stim[0] : 8'h00;
    @(negedge clk);
    start   = 1'b0;
    x_valid = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
    checkOutput("cleared_type", int'(attr_type), 0);
    checkOutput("cleared_nsamp", int'(n_samples), 0);
  endtask

  // Drives one full run from stim. gap inserts idle cycles before each
  // sample; noisy keeps start asserted throughout the busy period.
  task automatic applyStimulus(input int gap, input bit noisy, input bit release_rst);
    exp_t e;
    e = model();
    exp_q.push_back(e);
    runs++;
    startRun(release_rst);
    for (int i = 0; i <= e.decide; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        x_valid = 1'b0;
        x       = 8'h55;
        start   = noisy;
      end
      @(negedge clk);
      x       = stim[i];
      x_valid = 1'b1;
      start   = noisy;
    end
    @(negedge clk);
    x_valid = 1'b0;
    start   = noisy;
    checkOutput("done_pulse", int'(done), 1);
    checkOutput("busy_in_report", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_one_cycle", int'(done), 0);
    checkOutput("busy_back_idle", int'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      x_valid = 1'b1;
      x       = 8'h3C;
    end
    @(negedge clk);
    x_valid = 1'b0;
    checkOutput("idle_ignores_x", int'(busy), 0);
    checkOutput("hold_type", int'(attr_type), e.t);
    checkOutput("hold_nsamp", int'(n_samples), e.n);
  endtask

  initial begin
    int dc_before;
    total      = 0;
    bad        = 0;
    done_count = 0;
    runs       = 0;
    rst        = 1'b1;
    start      = 1'b0;
    x          = 8'h00;
    x_valid    = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_type", int'(attr_type), 0);
    checkOutput("rst_period", int'(period), 0);
    checkOutput("rst_transient", int'(transient), 0);
    checkOutput("rst_state", int'(attr_state), 0);
    checkOutput("rst_nsamp", int'(n_samples), 0);
    rst = 1'b0;
    @(negedge clk);

    stim = '{8'h00, 8'h00};
    applyStimulus(0, 1'b0, 1'b0);

    stim = '{8'h7C, 8'hB2, 8'h4D, 8'hB2};
    applyStimulus(0, 1'b0, 1'b0);

    stim = '{8'h38, 8'h1C, 8'h0E, 8'h38};
    applyStimulus(0, 1'b0, 1'b0);

    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'(i));
    applyStimulus(0, 1'b0, 1'b0);

    stim = '{8'h7C, 8'hB2, 8'h4D, 8'hB2};
    applyStimulus(2, 1'b1, 1'b0);

    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'($urandom_range(0, 7)));
    applyStimulus(1, 1'b0, 1'b0);

    stim = '{8'h01, 8'h02, 8'h03};
    startRun(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x       = stim[i];
      x_valid = 1'b1;
    end
    @(negedge clk);
    dc_before = done_count;
    x       = 8'h01;
    x_valid = 1'b1;
    rst     = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_type", int'(attr_type), 0);
    checkOutput("abort_period", int'(period), 0);
    checkOutput("abort_state", int'(attr_state), 0);
    checkOutput("abort_nsamp", int'(n_samples), 0);
    repeat (2) @(negedge clk);
    x_valid = 1'b0;
    checkOutput("no_done_after_abort", done_count, dc_before);

    stim = '{8'h00, 8'h00};
    applyStimulus(0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);
    checkOutput("done_total", done_count, runs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/attractor_classifier.md
ATTRACTOR_CLASSIFIER -- requirements
Module: attractor_classifier

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 16, history depth in states (legal range 2..16).
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-003 The block SHALL have these ports:
- start  in  1  begin a new classification run.
- x  in  8  current gene network state, from gene_net x_out.
- x_valid  in  1  x holds a new network state this cycle.
- busy  out  1  a run is in progress.
- done  out  1  one-cycle pulse; results are valid.
- attr_type  out  2  00 none, 01 fixed point, 10 cycle, 11 overflow.
- period  out  5  attractor length in states.
- transient  out  5  states before entering the attractor.
- attr_state  out  8  first repeated state.
- n_samples  out  5  samples accepted in the run.

Function
REQ-004 The FSM SHALL have three states: IDLE, TRACK, REPORT.
REQ-005 IDLE: start=1 SHALL clear the history valid bits and the sample index n, then go to TRACK the next cycle.
REQ-006 A run SHALL ignore any x_valid sample that arrives in the same cycle as start.
REQ-007 In IDLE, x_valid SHALL be ignored.
REQ-008 In TRACK, each cycle with x_valid=1 SHALL accept one sample as index n and compare x against every valid history entry 0..n-1 in that cycle.
REQ-009 No match SHALL write x into entry n and increment n.
REQ-010 A match at entry k SHALL set period=n-k, transient=k, attr_state=x and n_samples=n+1, then go to REPORT.
- attr_type=01 if period==1, else 10.
REQ-011 History SHALL hold only distinct states, so at most one entry can match.
- If several entries match anyway, the lowest index SHALL win.
REQ-012 If the sample at n=DEPTH-1 has no match, the block SHALL set attr_type=11, period=0, transient=0, attr_state=x and n_samples=DEPTH, then go to REPORT.
REQ-013 In TRACK, cycles with x_valid=0 SHALL change nothing; there is no timeout.
REQ-014 REPORT SHALL last exactly one cycle with done=1, then return to IDLE.
- done SHALL rise in the cycle after the deciding sample is accepted.
REQ-015 busy SHALL be 1 in TRACK and REPORT, and 0 in IDLE.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 attr_type, period, transient, attr_state and n_samples SHALL be registered.
- They SHALL hold their values from REPORT until the next start is accepted.
- When start is accepted they SHALL clear to 0.
REQ-018 All counts SHALL be unsigned 5-bit values.
- n SHALL never exceed DEPTH and SHALL NOT wrap around.

Reset
REQ-019 While rst=1, the FSM SHALL be IDLE, and busy, done, attr_type, period, transient, attr_state, n_samples, n and all history valid bits SHALL be 0.
REQ-020 Asserting rst mid-run SHALL abort the run; no done pulse SHALL follow.
REQ-021 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-022 Fixed point: start, then x=0x00, 0x00 -> done one cycle after the 2nd sample; attr_type=01, period=1, transient=0, attr_state=0x00, n_samples=2.
REQ-023 Cycle with transient: x=0x7C, 0xB2, 0x4D, 0xB2 -> attr_type=10, period=2, transient=1, attr_state=0xB2, n_samples=4.
REQ-024 Pure cycle: x=0x38, 0x1C, 0x0E, 0x38 -> attr_type=10, period=3, transient=0, attr_state=0x38.
REQ-025 Overflow: x=0x00..0x0F, 16 distinct values -> attr_type=11, period=0, n_samples=16, attr_state=0x0F.
REQ-026 Gapped x_valid with start pulses while busy -> the extra starts have no effect and the results match the ungapped run.
REQ-027 Reset mid-run: rst asserted after 3 samples -> all outputs 0 at once and no done pulse; a new run then classifies 0x00, 0x00 as a fixed point.
